// File: rtl/fnscatf_decoder_pipe.sv
// Pipelined FNS-CATF codeword decoder with valid/ready flow control.
// Stages: normalise -> two half partial sums -> final sum with range flag.
module fnscatf_decoder_pipe #(
  parameter int unsigned     CW_W      = 9,
  parameter int unsigned     DATA_W    = 8,
  parameter longint unsigned MAX_VALUE = (64'd1 << DATA_W) - 64'd1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   codein,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dataout,
  output logic              out_err
);

  localparam int unsigned SW = DATA_W + 1;
  localparam int unsigned QW = CW_W - 1;
  localparam int unsigned LO = QW / 2;

  typedef logic [SW-1:0] sum_t;

  // Fibonacci weight k with w[0]=1, w[1]=2.
  function automatic sum_t fib_w(input int unsigned k);
    sum_t a, b, t;
    a = sum_t'(1);
    b = sum_t'(2);
    for (int unsigned i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  logic              v1_q, v1_d, flag_q, flag_d;
  logic [QW-1:0]     q_q, q_d;
  logic              v2_q, v2_d;
  sum_t              lo_q, lo_d, hi_q, hi_d;
  logic              v3_q, v3_d;
  logic [DATA_W-1:0] dataout_q, dataout_d;
  logic              err_q, err_d;
  logic              ld1, ld2, ld3;
  sum_t              sum;

  always_comb begin
    // Each stage may load when empty or when the stage after it is loading.
    ld3 = !v3_q || out_ready;
    ld2 = !v2_q || ld3;
    ld1 = !v1_q || ld2;

    v1_d      = v1_q;
    flag_d    = flag_q;
    q_d       = q_q;
    v2_d      = v2_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    v3_d      = v3_q;
    dataout_d = dataout_q;
    err_d     = err_q;
    sum       = lo_q + hi_q;

    if (ld1) v1_d = in_valid;
    if (ld1 && in_valid) begin
      flag_d = codein[CW_W-1];
      q_d    = codein[CW_W-1] ? {1'b0, codein[CW_W-2:1]} : codein[CW_W-2:0];
    end

    if (ld2) v2_d = v1_q;
    if (ld2 && v1_q) begin
      lo_d = '0;
      hi_d = flag_q ? fib_w(CW_W - 1) : '0;
      for (int unsigned k = 0; k < QW; k++) begin
        if (q_q[k]) begin
          if (k < LO) lo_d = lo_d + fib_w(k);
          else        hi_d = hi_d + fib_w(k);
        end
      end
    end

    if (ld3) v3_d = v2_q;
    if (ld3 && v2_q) begin
      dataout_d = sum[DATA_W-1:0];
      err_d     = 64'(sum) > MAX_VALUE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      flag_q    <= 1'b0;
      q_q       <= '0;
      v2_q      <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
      v3_q      <= 1'b0;
      dataout_q <= '0;
      err_q     <= 1'b0;
    end else begin
      v1_q      <= v1_d;
      flag_q    <= flag_d;
      q_q       <= q_d;
      v2_q      <= v2_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      v3_q      <= v3_d;
      dataout_q <= dataout_d;
      err_q     <= err_d;
    end
  end

  assign in_ready  = ld1;
  assign out_valid = v3_q;
  assign dataout   = dataout_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_fnscatf_decoder_pipe.sv
// Bench for fnscatf_decoder_pipe: five parameterisations driven one at a time,
// checked against an arithmetic Fibonacci-weight model through a scoreboard.
module tb_fnscatf_decoder_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] cw;
  logic        iv   [5];
  logic        ordy [5];

  logic        ir0, ir1, ir2, ir3, ir4;
  logic        ov0, ov1, ov2, ov3, ov4;
  logic        oe0, oe1, oe2, oe3, oe4;
  logic [7:0]  od0, od1;
  logic [2:0]  od2;
  logic [8:0]  od3;
  logic [11:0] od4;

  always #5 clk = ~clk;

  fnscatf_decoder_pipe #(.CW_W(9), .DATA_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0), .codein(cw[8:0]),
    .out_valid(ov0), .out_ready(ordy[0]), .dataout(od0), .out_err(oe0));
  fnscatf_decoder_pipe #(.CW_W(9), .DATA_W(8), .MAX_VALUE(100)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1), .codein(cw[8:0]),
    .out_valid(ov1), .out_ready(ordy[1]), .dataout(od1), .out_err(oe1));
  fnscatf_decoder_pipe #(.CW_W(3), .DATA_W(3)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2), .codein(cw[2:0]),
    .out_valid(ov2), .out_ready(ordy[2]), .dataout(od2), .out_err(oe2));
  fnscatf_decoder_pipe #(.CW_W(12), .DATA_W(9)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir3), .codein(cw[11:0]),
    .out_valid(ov3), .out_ready(ordy[3]), .dataout(od3), .out_err(oe3));
  fnscatf_decoder_pipe #(.CW_W(16), .DATA_W(12)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[4]), .in_ready(ir4), .codein(cw[15:0]),
    .out_valid(ov4), .out_ready(ordy[4]), .dataout(od4), .out_err(oe4));

  int          sel = 0;
  logic        ir_s, ov_s, oe_s;
  logic [31:0] od_s;

  always_comb begin
    ir_s = ir0; ov_s = ov0; oe_s = oe0; od_s = 32'(od0);
    case (sel)
      1: begin ir_s = ir1; ov_s = ov1; oe_s = oe1; od_s = 32'(od1); end
      2: begin ir_s = ir2; ov_s = ov2; oe_s = oe2; od_s = 32'(od2); end
      3: begin ir_s = ir3; ov_s = ov3; oe_s = oe3; od_s = 32'(od3); end
      4: begin ir_s = ir4; ov_s = ov4; oe_s = oe4; od_s = 32'(od4); end
      default: ;
    endcase
  end

  int              CWW  [5] = '{9, 9, 3, 12, 16};
  int              DW   [5] = '{8, 8, 3, 9, 12};
  longint unsigned MAXV [5] = '{255, 100, 7, 511, 4095};

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          c;
  } exp_t;

  exp_t        exp_q [$];
  int          errors = 0, checks = 0, cyc = 0, n_out = 0;
  bit          lat_chk = 1'b0, hold_pend = 1'b0, force_exp = 1'b0;
  logic [31:0] hold_d, fx_d;
  logic        hold_e, fx_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Decoded value from the weight rules: {err, data}.
  function automatic logic [32:0] model(input int s, input logic [15:0] code);
    longint unsigned fib [32];
    longint unsigned total = 0;
    int              w = CWW[s];
    bit              flag;
    logic [15:0]     bits;
    int              nb;
    fib[0] = 1;
    fib[1] = 2;
    for (int i = 2; i < 32; i++) fib[i] = fib[i-1] + fib[i-2];
    flag = code[w-1];
    bits = flag ? (code >> 1) : code;
    nb   = flag ? w - 2 : w - 1;
    for (int k = 0; k < nb; k++) if (bits[k]) total += fib[k];
    if (flag) total += fib[w-1];
    return {total > MAXV[s], 32'(total % (64'd1 << DW[s]))};
  endfunction

  task automatic cyc_step(input bit v, input logic [15:0] code, input bit rdy, output bit acc);
    exp_t        e;
    logic [32:0] m;
    @(negedge clk);
    if (hold_pend) begin
      chk("hold_valid", 32'(ov_s), 32'd1);
      chk("hold_data", od_s, hold_d);
      chk("hold_err", 32'(oe_s), 32'(hold_e));
    end
    iv[sel] = v; cw = code; ordy[sel] = rdy;
    #1;
    if (ov_s && rdy) begin
      if (exp_q.size() == 0) chk("spurious_out", 32'(ov_s), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("data", od_s, e.d);
        chk("err", 32'(oe_s), 32'(e.e));
        if (lat_chk) chk("latency", 32'(cyc), 32'(e.c + 3));
        n_out++;
      end
    end
    hold_pend = ov_s && !rdy;
    hold_d = od_s;
    hold_e = oe_s;
    acc = v && ir_s;
    if (acc) begin
      if (force_exp) begin e.d = fx_d; e.e = fx_e; end
      else begin m = model(sel, code); e.d = m[31:0]; e.e = m[32]; end
      e.c = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    bit a;
    while (exp_q.size() > 0 && n < 50) begin
      cyc_step(1'b0, '0, 1'b1, a);
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  logic [15:0] dir_code [5] = '{16'h001, 16'h006, 16'h080, 16'h103, 16'h1FF};
  logic [31:0] dir_exp  [5] = '{1, 5, 34, 56, 108};
  logic [31:0] ones_exp [5] = '{0, 0, 4, 464, 3192};
  logic [15:0] pend [$];
  logic [15:0] mask;
  bit          acc;
  int          acc_cnt, base_out, n;

  initial begin
    cw = '0;
    for (int i = 0; i < 5; i++) begin iv[i] = 1'b0; ordy[i] = 1'b1; end
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 32'(ov_s), 32'd0);
    chk("rst_dataout", od_s, 32'd0);
    chk("rst_out_err", 32'(oe_s), 32'd0);
    chk("rst_in_ready", 32'(ir_s), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed decode values with exact latency.
    sel = 0; lat_chk = 1'b1; force_exp = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fx_d = dir_exp[i]; fx_e = 1'b0;
      cyc_step(1'b1, dir_code[i], 1'b1, acc);
      chk("dir_accept", 32'(acc), 32'd1);
    end
    force_exp = 1'b0;
    drain();

    // Back-to-back random stream.
    base_out = n_out;
    for (int i = 0; i < 200; i++) begin
      cyc_step(1'b1, 16'($urandom) & 16'h1FF, 1'b1, acc);
      chk("stream_accept", 32'(acc), 32'd1);
    end
    drain();
    chk("stream_count", 32'(n_out - base_out), 32'd200);

    // Backpressure: five words offered with the sink stalled.
    lat_chk = 1'b0; base_out = n_out; acc_cnt = 0; n = 0;
    for (int i = 0; i < 5; i++) pend.push_back(16'($urandom) & 16'h1FF);
    while (pend.size() > 0 && n < 40) begin
      cyc_step(1'b1, pend[0], n >= 5, acc);
      if (acc) pend.pop_front();
      if (acc && n < 5) acc_cnt++;
      n++;
      if (n == 5) begin
        #1;
        chk("bp_accepted", 32'(acc_cnt), 32'd3);
        chk("bp_in_ready", 32'(ir_s), 32'd0);
      end
    end
    chk("bp_all_sent", 32'(pend.size()), 32'd0);
    drain();
    chk("bp_delivered", 32'(n_out - base_out), 32'd5);

    // Reset with three words in flight.
    for (int i = 0; i < 3; i++) cyc_step(1'b1, 16'($urandom) & 16'h1FF, 1'b0, acc);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(ov_s), 32'd0);
    chk("midrst_dataout", od_s, 32'd0);
    chk("midrst_out_err", 32'(oe_s), 32'd0);
    chk("midrst_in_ready", 32'(ir_s), 32'd1);
    exp_q.delete(); hold_pend = 1'b0; iv[0] = 1'b0; ordy[0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc_step(1'b0, '0, 1'b1, acc);
      #1 chk("post_rst_quiet", 32'(ov_s), 32'd0);
    end

    // Range flag with MAX_VALUE = 100.
    sel = 1; lat_chk = 1'b1; force_exp = 1'b1;
    fx_d = 108; fx_e = 1'b1;
    cyc_step(1'b1, 16'h1FF, 1'b1, acc);
    fx_d = 56; fx_e = 1'b0;
    cyc_step(1'b1, 16'h103, 1'b1, acc);
    force_exp = 1'b0;
    drain();

    // Width sweep with random gaps on both sides, then the all-ones word.
    lat_chk = 1'b0;
    for (int s = 2; s < 5; s++) begin
      sel = s;
      mask = 16'((32'd1 << CWW[s]) - 1);
      base_out = n_out;
      for (int i = 0; i < 150; i++)
        cyc_step($urandom_range(0, 9) < 7, 16'($urandom) & mask, $urandom_range(0, 9) < 7, acc);
      force_exp = 1'b1; fx_d = ones_exp[s]; fx_e = 1'b0;
      n = 0; acc = 1'b0;
      while (!acc && n < 20) begin
        cyc_step(1'b1, mask, 1'b1, acc);
        n++;
      end
      chk("ones_accept", 32'(acc), 32'd1);
      force_exp = 1'b0;
      drain();
      chk("sweep_some_out", 32'(n_out - base_out > 20), 32'd1);
      iv[s] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fnscatf_decoder_pipe.md
# fnscatf_decoder_pipe

Parametrised, pipelined FNS-CATF decoder: accepts one CATF codeword per clock over a valid/ready handshake and returns the decoded binary data word three cycles later. It generalises the fixed-width decoder core to any codeword width, computing the Fibonacci weights at elaboration. It also adds backpressure and a configurable range-violation flag. It sits on the receive side of a CAC link, between the codeword capture register and the data sink.

## Interface
- CW_W, 9: codeword width in bits; legal range 3..32.
- DATA_W, 8: decoded data width; must hold the sum of all weights applied to a legal codeword.
- MAX_VALUE, 2**DATA_W-1: largest legal decoded value; larger results raise out_err.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  codein carries a codeword.
- in_ready  output  1  block accepts codein this cycle.
- codein  input  CW_W  CATF codeword; bit CW_W-1 is the flag bit.
- out_valid  output  1  dataout/out_err valid.
- out_ready  input  1  sink accepts the output this cycle.
- dataout  output  DATA_W  decoded value.
- out_err  output  1  decoded value > MAX_VALUE.

## Operation
- Weights: w[0]=1, w[1]=2, w[k]=w[k-1]+w[k-2]; w[CW_W-1] applies to the flag bit. For 9 bits: 1,2,3,5,8,13,21,34,55. Computed by elaboration-time function; no lookup ports.
- Normalisation: flag=0 -> q = codein[CW_W-2:0]; flag=1 -> q = {1'b0, codein[CW_W-2:1]} (codein[0] ignored).
- Result = flag*w[CW_W-1] + sum over k of q[k]*w[k]; accumulate at DATA_W+1 bits internally so overflow is detectable. dataout = low DATA_W bits; out_err = (full sum > MAX_VALUE).
- Pipeline, each stage with its own valid bit:
  - S1 registers flag and q.
  - S2 registers two partial sums: the low half of q, and the high half of q plus the flag term.
  - S3 registers the final sum, dataout and out_err.
- Advance rule: stage n loads when stage n is empty or its contents move on this cycle. S3 moves on when out_valid && out_ready.
- in_ready = !S1.valid || S1 moves on. This is combinational from out_ready through the stall chain, with no other combinational paths.
- A transfer occurs only on a cycle where valid && ready. Stage data registers load only on advance, so a stalled output holds steady.
- There is no internal error state. out_err is per-word and informational, and the word is still delivered.

## Timing
- Reset (rst_n low, async) clears all stage valid bits, dataout, and out_err: out_valid=0, dataout=0, out_err=0, in_ready=1 as soon as reset is applied.
- Reset deassertion is synchronised by the system. The first transfer is possible on the first rising edge with rst_n high.
- Reset mid-operation discards all in-flight words with no partial output.
- Latency: a word accepted at edge t is presented with out_valid=1 after edge t+3.
- Throughput: one word per clock with out_ready held high. Bubbles in the input propagate as bubbles in the output.
- Capacity: 3 words. With out_ready low, the block accepts up to 3 words after which in_ready=0.
- Simultaneous accept and deliver while full: both happen on the same edge and the pipeline stays full.
- If out_valid is high and out_ready is low, dataout and out_err are held stable until the handshake completes.

## Test plan
- Reset: rst_n low mid-stream with 3 words in flight -> out_valid=0, dataout=0, out_err=0, in_ready=1 immediately. No word emerges after release.
- Decode values (CW_W=9, out_ready=1):
  - 9'h001 -> 1
  - 9'h006 -> 5
  - 9'h080 -> 34
  - 9'h103 -> 56
  - 9'h1FF -> 108
  - Each arrives exactly 3 cycles after acceptance, out_err=0.
- Streaming: 200 back-to-back random codewords with out_ready=1 -> 200 outputs in order on consecutive cycles, each matching the software model.
- Backpressure: out_ready=0 while feeding 5 words -> exactly 3 accepted, in_ready=0. The first output is held stable. Raise out_ready -> all 5 delivered in order with no loss or duplication.
- Range flag (MAX_VALUE=100): 9'h1FF -> dataout=108, out_err=1. 9'h103 -> dataout=56, out_err=0.
- Width sweep: CW_W=3, 12, 16 with random stimulus plus random in_valid/out_ready gaps -> every output matches the model, and the all-ones input gives the expected maximum sum.
